i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_W, default 16, sample width (signed Q1.15).
REQ-002 Parameter SLOT_W, default 32, BCLK periods per channel slot; SLOT_W >= DATA_W.
REQ-003 Parameter HALF_DIV, default 16, clk cycles per BCLK half-period; 100 MHz gives 3.125 MHz BCLK and 48.828 kHz frame rate.
REQ-004 Parameter FIFO_DEPTH, default 4, input FIFO entries (power of two).
REQ-005 Port clk, input, 1, the 100 MHz system clock; the only clock.
REQ-006 Port rst, input, 1, reset; synchronous, active-high.
REQ-007 Port s_data, input, DATA_W, signed filtered sample from the FIR output stage.
REQ-008 Port s_valid, input, 1, one-cycle strobe qualifying s_data.
REQ-009 Port bclk, output, 1, I2S bit clock, registered.
REQ-010 Port lrclk, output, 1, I2S word select, registered; 0 is left, 1 is right.
REQ-011 Port sdata, output, 1, I2S serial data, registered, MSB first.
REQ-012 Port overrun, output, 1, one-cycle pulse when a sample is dropped because the FIFO is full.
REQ-013 Port underrun, output, 1, one-cycle pulse when a frame starts with the FIFO empty.
REQ-014 Port fifo_level, output, clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-015 Divider counts 0..HALF_DIV-1; at terminal count bclk toggles and the counter wraps to 0.
REQ-016 bit_cnt (0..2*SLOT_W-1) increments modulo 2*SLOT_W on the clk edge where bclk goes 1->0; sdata and lrclk update on that same edge only.
REQ-017 lrclk is 1 for bit_cnt in [SLOT_W-1, 2*SLOT_W-2] and 0 otherwise, giving the standard I2S one-BCLK lead before each slot's MSB.
REQ-018 With p = bit_cnt mod SLOT_W: sdata = shadow[DATA_W-1-p] for p < DATA_W, else 0.
REQ-019 When bit_cnt wraps to 0, a non-empty FIFO pops its head into shadow; both left and right slots transmit that one mono word.
REQ-020 When bit_cnt wraps to 0 and the FIFO is empty, shadow is retained (last sample repeats) and underrun pulses for that one clk cycle.
REQ-021 s_valid with FIFO not full writes s_data; s_valid with FIFO full drops s_data and pulses overrun in the next cycle.
REQ-022 Pop and push evaluate against the pre-cycle level with no bypass: when full, a simultaneous pop and push both succeed and the level stays FIFO_DEPTH; when empty, a simultaneous pop and push gives an underrun and the pushed word is stored.
REQ-023 fifo_level is registered and reflects all pushes and pops completed by the previous edge.
REQ-024 A sample accepted at least one clk before a frame-start edge appears as the MSB of that frame.

Reset
REQ-025 While rst=1 at a clk edge: bclk=0, lrclk=0, sdata=0, divider=0, bit_cnt=2*SLOT_W-1, shadow=0, FIFO empty, fifo_level=0, overrun=0, underrun=0.
REQ-026 Reset asserted mid-frame aborts the frame immediately; s_valid during reset is ignored.
REQ-027 The first BCLK falling edge after reset release (cycle 2*HALF_DIV) is a frame start and performs the REQ-019/020 pop.

Structure
REQ-028 Package i2s_pkg holds the DATA_W, SLOT_W, HALF_DIV and FIFO_DEPTH defaults and the clog2 width constant.
REQ-029 The FIFO is the sub-module i2s_tx_fifo (synchronous, single clock, level output); divider, bit counter and serializer stay in i2s_tx.

Verification
REQ-030 Reset, then idle for 4096 clk -> bclk period 32 clk, lrclk period 2048 clk, sdata all 0, underrun pulses once per frame starting at cycle 32.
REQ-031 Push 0x8001 before the first frame -> left and right slots each carry bits 1000000000000001 then 16 zeros; lrclk toggles one BCLK before each MSB.
REQ-032 Push 0x1234, 0x5678, 0x9ABC in cycles 1..3 -> fifo_level reads 3, then frames carry 0x1234, 0x5678, 0x9ABC in that order.
REQ-033 Push 6 samples back-to-back into an empty FIFO with no frame start -> first 4 are stored, overrun pulses twice, level = 4.
REQ-034 With FIFO full, s_valid coincident with frame-start pop -> no overrun, level stays 4; with FIFO empty at the same edge -> underrun, level becomes 1.
REQ-035 Assert rst at bit_cnt=20 of a frame holding 0x7FFF -> all outputs 0 next cycle, and after release the next frame follows REQ-027.

Source files
------------

// File: rtl/i2s_pkg.sv
// I2S transmitter shared definitions.
// Holds the default parameter values for the transmitter and its FIFO, the
// default FIFO level width, and a counter-width helper that never returns 0.
package i2s_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int SLOT_W_DEF     = 32;
  localparam int HALF_DIV_DEF   = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int LVL_W_DEF      = $clog2(FIFO_DEPTH_DEF) + 1;

  // Width of a counter covering 0..n-1; at least one bit so n=1 stays legal.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Sample FIFO feeding the I2S serializer.
// Single clock, synchronous active-high reset. push_i/pop_i are already
// qualified by the caller (never push when full without a pop, never pop
// when empty). rdata_o is the head entry, read combinationally.
// Ports:
//   clk, rst        clock, synchronous reset
//   push_i, wdata_i write strobe and data
//   pop_i           advance head
//   rdata_o         current head
//   full_o, empty_o occupancy flags from the registered level
//   level_o         registered occupancy 0..DEPTH
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int W     = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = cnt_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage has no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: buffers samples in a small FIFO and sends each one
// in both the left and right slots of a frame.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   s_data, s_valid   incoming sample and its one-cycle strobe
//   bclk, lrclk       registered bit clock and word select (0 = left)
//   sdata             registered serial data, MSB first
//   overrun           pulse: sample dropped because the FIFO was full
//   underrun          pulse: frame started with the FIFO empty
//   fifo_level        registered FIFO occupancy
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SLOT_W     = SLOT_W_DEF,
  parameter int HALF_DIV   = HALF_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic                          overrun,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BC_W = cnt_w(2 * SLOT_W);
  localparam int DIV_W = cnt_w(HALF_DIV);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(2 * SLOT_W - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  logic              div_tc, fall, frame_start, push, pop, full, empty;
  logic [DATA_W-1:0] head, sh;
  logic [BC_W-1:0]   p;

  i2s_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (s_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_comb begin
    div_tc      = (div_q == DIV_W'(HALF_DIV - 1));
    fall        = div_tc & bclk_q;
    frame_start = fall & (bit_cnt_q == BC_LAST);
    // Both decisions use the pre-cycle level: a pop frees a slot for a
    // same-cycle push, but a same-cycle push never feeds an empty pop.
    pop         = frame_start & ~empty;
    push        = s_valid & (~full | pop);

    div_d      = div_tc ? '0 : div_q + 1'b1;
    bclk_d     = bclk_q ^ div_tc;
    bit_cnt_d  = bit_cnt_q;
    shadow_d   = shadow_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    p          = '0;
    sh         = '0;

    if (fall) begin
      bit_cnt_d = (bit_cnt_q == BC_LAST) ? '0 : bit_cnt_q + 1'b1;
      if (pop) shadow_d = head;
      // Slot-relative bit position; shifting by p >= DATA_W yields the
      // zero padding at the tail of each slot for free.
      p       = (bit_cnt_d >= BC_W'(SLOT_W)) ? bit_cnt_d - BC_W'(SLOT_W) : bit_cnt_d;
      sh      = shadow_d << p;
      sdata_d = sh[DATA_W-1];
      // Word select leads each slot's MSB by one BCLK.
      lrclk_d = (bit_cnt_d >= BC_W'(SLOT_W - 1)) && (bit_cnt_d <= BC_W'(2 * SLOT_W - 2));
    end

    overrun_d  = s_valid & ~push;
    underrun_d = frame_start & empty;
  end

  // bit_cnt resets to its last value so the first BCLK fall is a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      bit_cnt_q  <= BC_LAST;
      shadow_q   <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shadow_q   <= shadow_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with default parameters (16-bit data, 32-bit
// slots, 32-clk BCLK period, 4-deep FIFO). Cycle N is the state seen after
// the Nth rising clk edge following reset release.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        bclk, lrclk, sdata, overrun, underrun;
  logic [2:0]  fifo_level;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  localparam logic [63:0] LR_EXP = 64'h7FFF_FFFF_8000_0000;

  typedef struct {
    logic        vld;
    logic [15:0] data;
    logic [2:0]  lvl;
    logic        ov;
  } vec_t;

  vec_t tbl [8];

  i2s_tx dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .overrun    (overrun),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic drive(input logic v, input logic [15:0] d);
    s_valid = v;
    s_data  = d;
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1;
    drive(v, 16'hBEEF);
    repeat (3) step();
    rst = 1'b0;
    drive(1'b0, 16'h0000);
    cyc = 0;
  endtask

  // Expected serial bits of one frame carrying word w, bit b at index b.
  function automatic logic [63:0] exp_frame(input logic [15:0] w);
    logic [63:0] v;
    logic [15:0] t;
    for (int b = 0; b < 64; b++) begin
      t    = w << (b % 32);
      v[b] = t[15];
    end
    return v;
  endfunction

  task automatic check_frame(input string nm, input int fs, input logic [15:0] w);
    logic [63:0] sd, lr;
    sd = '0;
    lr = '0;
    for (int b = 0; b < 64; b++) begin
      run_to(fs + 32 * b);
      sd[b] = sdata;
      lr[b] = lrclk;
    end
    chk({nm, "_sdata"}, sd, exp_frame(w));
    chk({nm, "_lrclk"}, lr, LR_EXP);
  endtask

  initial begin
    int bclk_rise, bclk_first, lr_rise, lr_fall, lr_first_rise, lr_first_fall;
    int ur_cnt, ur_first, ur_last, ov_cnt, sd_ones;
    logic pb, pl;

    tbl[0] = '{1'b1, 16'h1111, 3'd1, 1'b0};
    tbl[1] = '{1'b1, 16'h2222, 3'd2, 1'b0};
    tbl[2] = '{1'b1, 16'h3333, 3'd3, 1'b0};
    tbl[3] = '{1'b1, 16'h4444, 3'd4, 1'b0};
    tbl[4] = '{1'b1, 16'h5555, 3'd4, 1'b1};
    tbl[5] = '{1'b1, 16'h6666, 3'd4, 1'b1};
    tbl[6] = '{1'b0, 16'h0000, 3'd4, 1'b0};
    tbl[7] = '{1'b0, 16'h0000, 3'd4, 1'b0};

    // Reset state, with s_valid held high to show it is ignored.
    do_reset(1'b1);
    chk("rst_bclk",     64'(bclk),       64'd0);
    chk("rst_lrclk",    64'(lrclk),      64'd0);
    chk("rst_sdata",    64'(sdata),      64'd0);
    chk("rst_overrun",  64'(overrun),    64'd0);
    chk("rst_underrun", 64'(underrun),   64'd0);
    chk("rst_level",    64'(fifo_level), 64'd0);

    // Idle run: clock periods, frame-start underruns, silent data.
    bclk_rise = 0; bclk_first = -1; lr_rise = 0; lr_fall = 0;
    lr_first_rise = -1; lr_first_fall = -1;
    ur_cnt = 0; ur_first = -1; ur_last = -1; ov_cnt = 0; sd_ones = 0;
    pb = bclk; pl = lrclk;
    for (int i = 0; i < 4096; i++) begin
      step();
      if (bclk && !pb) begin
        bclk_rise++;
        if (bclk_first < 0) bclk_first = cyc;
      end
      if (lrclk && !pl) begin
        lr_rise++;
        if (lr_first_rise < 0) lr_first_rise = cyc;
      end
      if (!lrclk && pl) begin
        lr_fall++;
        if (lr_first_fall < 0) lr_first_fall = cyc;
      end
      if (underrun) begin
        ur_cnt++;
        if (ur_first < 0) ur_first = cyc;
        ur_last = cyc;
      end
      if (overrun) ov_cnt++;
      if (sdata) sd_ones++;
      pb = bclk;
      pl = lrclk;
    end
    chk("idle_bclk_rises",   64'(bclk_rise),     64'd128);
    chk("idle_bclk_first",   64'(bclk_first),    64'd16);
    chk("idle_lr_rises",     64'(lr_rise),       64'd2);
    chk("idle_lr_falls",     64'(lr_fall),       64'd2);
    chk("idle_lr_first_up",  64'(lr_first_rise), 64'd1024);
    chk("idle_lr_first_dn",  64'(lr_first_fall), 64'd2048);
    chk("idle_ur_count",     64'(ur_cnt),        64'd2);
    chk("idle_ur_first",     64'(ur_first),      64'd32);
    chk("idle_ur_last",      64'(ur_last),       64'd2080);
    chk("idle_ov_count",     64'(ov_cnt),        64'd0);
    chk("idle_sdata_ones",   64'(sd_ones),       64'd0);

    // Single sample 0x8001 ahead of the first frame.
    do_reset(1'b0);
    drive(1'b1, 16'h8001);
    step();
    drive(1'b0, 16'h0000);
    chk("w8001_level1", 64'(fifo_level), 64'd1);
    run_to(32);
    chk("w8001_no_ur",  64'(underrun),   64'd0);
    chk("w8001_level0", 64'(fifo_level), 64'd0);
    check_frame("w8001", 32, 16'h8001);

    // Three samples, delivered one per frame in order; then repeat on empty.
    do_reset(1'b0);
    drive(1'b1, 16'h1234); step();
    drive(1'b1, 16'h5678); step();
    drive(1'b1, 16'h9ABC); step();
    drive(1'b0, 16'h0000);
    chk("seq_level3", 64'(fifo_level), 64'd3);
    run_to(32);
    chk("seq_level2", 64'(fifo_level), 64'd2);
    check_frame("seq_f0", 32,   16'h1234);
    check_frame("seq_f1", 2080, 16'h5678);
    check_frame("seq_f2", 4128, 16'h9ABC);
    run_to(6176);
    chk("seq_ur_empty", 64'(underrun), 64'd1);
    check_frame("seq_repeat", 6176, 16'h9ABC);

    // Overflow table: six pushes into an empty FIFO, no frame start.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].vld, tbl[i].data);
      step();
      chk($sformatf("ovf_level_%0d", i), 64'(fifo_level), 64'(tbl[i].lvl));
      chk($sformatf("ovf_ov_%0d", i),    64'(overrun),    64'(tbl[i].ov));
      chk($sformatf("ovf_ur_%0d", i),    64'(underrun),   64'd0);
    end
    drive(1'b0, 16'h0000);

    // Full FIFO: push coincident with frame-start pop is accepted.
    run_to(31);
    drive(1'b1, 16'h7777);
    step();
    drive(1'b0, 16'h0000);
    chk("full_pop_ov",    64'(overrun),    64'd0);
    chk("full_pop_ur",    64'(underrun),   64'd0);
    chk("full_pop_level", 64'(fifo_level), 64'd4);
    check_frame("full_pop", 32, 16'h1111);

    // Empty FIFO: push coincident with frame start underruns, word kept.
    do_reset(1'b0);
    run_to(31);
    drive(1'b1, 16'hABCD);
    step();
    drive(1'b0, 16'h0000);
    chk("empty_push_ur",    64'(underrun),   64'd1);
    chk("empty_push_ov",    64'(overrun),    64'd0);
    chk("empty_push_level", 64'(fifo_level), 64'd1);
    check_frame("empty_f0", 32,   16'h0000);
    check_frame("empty_f1", 2080, 16'hABCD);

    // Reset mid-frame at bit_cnt 20 while sending 0x7FFF.
    do_reset(1'b0);
    drive(1'b1, 16'h7FFF);
    step();
    drive(1'b0, 16'h0000);
    run_to(64);
    chk("midrst_bit1", 64'(sdata), 64'd1);
    run_to(690);
    chk("midrst_bclk_hi", 64'(bclk), 64'd1);
    rst = 1'b1;
    drive(1'b1, 16'h5555);
    step();
    chk("midrst_bclk",  64'(bclk),       64'd0);
    chk("midrst_lrclk", 64'(lrclk),      64'd0);
    chk("midrst_sdata", 64'(sdata),      64'd0);
    chk("midrst_ov",    64'(overrun),    64'd0);
    chk("midrst_ur",    64'(underrun),   64'd0);
    chk("midrst_level", 64'(fifo_level), 64'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0000);
    cyc = 0;
    run_to(31);
    chk("postrst_bclk31", 64'(bclk), 64'd1);
    run_to(32);
    chk("postrst_ur",    64'(underrun),   64'd1);
    chk("postrst_level", 64'(fifo_level), 64'd0);
    check_frame("postrst", 32, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
